// File: rtl/cxs_h2c_intr_pkg.sv
// cxs_h2c_intr_pkg: shared channel state encoding and register width for the h2c interrupt generator
package cxs_h2c_intr_pkg;
  localparam int REG_W = 32;
  typedef enum logic [1:0] {
    ST_IDLE    = 2'b00,
    ST_ASSERT  = 2'b01,
    ST_RELEASE = 2'b10,
    ST_DONE    = 2'b11
  } chan_state_e;
  localparam chan_state_e ST_PULSE = ST_ASSERT;
endpackage

// File: rtl/cxs_h2c_intr_chan.sv
// cxs_h2c_intr_chan: one h2c interrupt channel (req/ack handshake FSM plus sticky status); CXS_H2C_INTR_PULSE_EN selects single-cycle pulse delivery
module cxs_h2c_intr_chan
  import cxs_h2c_intr_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic i_req,
  input  logic i_ack,
  input  logic i_status_clear,
  output logic o_intr,
  output logic o_req_clr_we,
  output logic o_status,
  output logic o_spurious
);
  chan_state_e r_state;
  logic r_intr;
  logic r_clr_we;
  logic r_status;
  logic w_start;
  logic w_set;
`ifdef CXS_H2C_INTR_PULSE_EN
  logic w_unused_ack;
  assign w_unused_ack = i_ack;
  assign w_start = i_req;
  assign w_set = r_state == ST_PULSE;
  assign o_spurious = 1'b0;
`else
  assign w_start = i_req & ~i_ack;
  assign w_set = (r_state == ST_RELEASE) & ~i_ack;
  assign o_spurious = i_ack & ~i_req & ((r_state == ST_IDLE) | (r_state == ST_DONE));
`endif
  assign o_intr = r_intr;
  assign o_req_clr_we = r_clr_we;
  assign o_status = r_status;
  // Channel FSM: a completion sets status (set beats clear) and clears the host request bit once
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_intr <= 1'b0;
      r_clr_we <= 1'b0;
      r_status <= 1'b0;
    end else begin
      r_clr_we <= w_set;
      r_status <= w_set | (r_status & ~i_status_clear);
      case (r_state)
        ST_IDLE: if (w_start) begin
          r_state <= ST_ASSERT;
          r_intr <= 1'b1;
        end
`ifdef CXS_H2C_INTR_PULSE_EN
        ST_PULSE: begin
          r_state <= ST_DONE;
          r_intr <= 1'b0;
        end
`else
        ST_ASSERT: if (i_ack) begin
          r_state <= ST_RELEASE;
          r_intr <= 1'b0;
        end
        ST_RELEASE: if (!i_ack) r_state <= ST_DONE;
`endif
        ST_DONE: if (!i_req) r_state <= ST_IDLE;
        default: r_state <= ST_IDLE;
      endcase
    end
  end
endmodule

// File: rtl/cxs_h2c_intr_gen.sv
// cxs_h2c_intr_gen: host-to-card interrupt generator, one handshake channel per request bit; CXS_H2C_INTR_PULSE_EN selects pulse mode
module cxs_h2c_intr_gen
  import cxs_h2c_intr_pkg::*;
#(
  parameter int NUM_INTR = 128
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [NUM_INTR-1:0] intr_h2c_req,
  input  logic [NUM_INTR-1:0] intr_h2c_status_clear,
  input  logic [NUM_INTR-1:0] intr_h2c_done_enable,
  output logic [NUM_INTR-1:0] h2c_intr_out,
  input  logic [NUM_INTR-1:0] h2c_intr_ack,
  output logic [NUM_INTR-1:0] ih2rb_intr_h2c_req_clr,
  output logic [NUM_INTR-1:0] ih2rb_intr_h2c_req_clr_we,
  output logic [NUM_INTR-1:0] ih2rb_intr_h2c_status,
  output logic [NUM_INTR-1:0] ih2rb_intr_h2c_status_we,
  output logic                ih2rb_intr_h2c_spurious,
  output logic                h2c_done_irq
);
  logic [NUM_INTR-1:0] w_spur;
  logic r_status_we;
  logic r_spurious;
  logic r_done_irq;
  for (genvar i = 0; i < NUM_INTR; i++) begin : g_chan
    cxs_h2c_intr_chan u_chan (
      .clk            (clk),
      .reset          (reset),
      .i_req          (intr_h2c_req[i]),
      .i_ack          (h2c_intr_ack[i]),
      .i_status_clear (intr_h2c_status_clear[i]),
      .o_intr         (h2c_intr_out[i]),
      .o_req_clr_we   (ih2rb_intr_h2c_req_clr_we[i]),
      .o_status       (ih2rb_intr_h2c_status[i]),
      .o_spurious     (w_spur[i])
    );
  end
  assign ih2rb_intr_h2c_req_clr = '0;
  assign ih2rb_intr_h2c_status_we = {NUM_INTR{r_status_we}};
  assign ih2rb_intr_h2c_spurious = r_spurious;
  assign h2c_done_irq = r_done_irq;
  // Status write-enable, sticky spurious flag and the level completion interrupt
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_status_we <= 1'b0;
      r_spurious <= 1'b0;
      r_done_irq <= 1'b0;
    end else begin
      r_status_we <= 1'b1;
      r_spurious <= r_spurious | (|w_spur);
      r_done_irq <= |(ih2rb_intr_h2c_status & intr_h2c_done_enable);
    end
  end
endmodule

// File: doc/cxs_h2c_intr_gen.md
# cxs_h2c_intr_gen

Host-to-card interrupt generator for the CXS PCIe-host bridge; the h2c counterpart of the c2h interrupt collector. Takes per-bit interrupt requests written by the host into the register block and delivers each one to the DUT over a per-bit 4-phase req/ack handshake. It reports completion back to the register block with write enables and raises a level completion interrupt toward the host.

## Interface
- NUM_INTR, 128, number of h2c interrupt lines; multiple of 32.
- clk  in  1  bridge clock.
- reset  in  1  asynchronous, active-high reset.
- intr_h2c_req  in  NUM_INTR  host request bits, i.e. the intr_h2c_0..3 registers concatenated with bit 0 = reg0[0].
- intr_h2c_status_clear  in  NUM_INTR  host write-1-to-clear of completion status.
- intr_h2c_done_enable  in  NUM_INTR  completion-interrupt enable per bit.
- h2c_intr_out  out  NUM_INTR  interrupt lines to the DUT, registered.
- h2c_intr_ack  in  NUM_INTR  per-bit DUT acknowledge.
- ih2rb_intr_h2c_req_clr  out  NUM_INTR  value 0 written back to the request bits.
- ih2rb_intr_h2c_req_clr_we  out  NUM_INTR  one-cycle write enable that clears the request bit.
- ih2rb_intr_h2c_status  out  NUM_INTR  sticky completion status.
- ih2rb_intr_h2c_status_we  out  NUM_INTR  all ones when out of reset, 0 in reset.
- ih2rb_intr_h2c_spurious  out  1  sticky flag: an ack was seen on an idle channel.
- h2c_done_irq  out  1  level interrupt to the host.

## Operation
- Each bit runs an independent channel FSM with states IDLE, ASSERT, RELEASE and DONE.
  - IDLE: if req=1 and ack=0, go to ASSERT. h2c_intr_out is 0.
  - ASSERT: h2c_intr_out is 1. On ack=1, go to RELEASE.
  - RELEASE: h2c_intr_out is 0. On ack=0, go to DONE. In the same cycle, set status and pulse req_clr_we for 1 cycle.
  - DONE: wait for req=0, then go to IDLE. This guarantees one delivery per host write.
- Request high in IDLE while ack is still high: stay in IDLE until ack drops.
- Status bit:
  - Set on the RELEASE→DONE transition.
  - Cleared by intr_h2c_status_clear.
  - Simultaneous set and clear: set wins.
- Spurious flag:
  - Set when ack=1 on a channel in IDLE or DONE with req=0.
  - Cleared only by reset.
- h2c_done_irq = registered OR-reduction of (status & done_enable).
- Request dropped by the host during ASSERT or RELEASE: ignored. The handshake completes normally and status is still set.

## Timing
- All outputs are registered.
- Reset values: h2c_intr_out=0, status=0, status_we=0, req_clr=0, req_clr_we=0, spurious=0, h2c_done_irq=0, every FSM in IDLE.
- Latencies:
  - req sampled high at edge N: h2c_intr_out=1 after edge N.
  - ack sampled high at edge M: h2c_intr_out=0 after edge M.
  - ack sampled low at edge K: status=1 and req_clr_we=1 after edge K. req_clr_we is 0 again after edge K+1.
  - h2c_done_irq follows status by one further edge (K+1).
- Minimum delivery time: 3 cycles, request to status.
- Reset asserted mid-handshake:
  - h2c_intr_out drops asynchronously and every FSM returns to IDLE.
  - A request bit still set after reset restarts delivery.

## Configuration
- CXS_H2C_INTR_PULSE_EN defined: pulse mode.
  - Channel goes IDLE→PULSE→DONE, with h2c_intr_out high for exactly 1 cycle.
  - Status and req_clr_we are asserted on the edge that ends the pulse.
  - h2c_intr_ack is ignored and the spurious flag is tied to 0.
- Undefined: full 4-phase handshake as described above.

## Structure
- Package cxs_h2c_intr_pkg holds:
  - the channel state encoding (IDLE=2'b00, ASSERT=2'b01, RELEASE=2'b10, DONE=2'b11; PULSE reuses ASSERT);
  - the REG_W=32 constant.
- Sub-module cxs_h2c_intr_chan: one channel FSM plus its status bit. It is instantiated NUM_INTR times in a generate loop.
- The top level holds the spurious OR-reduction and the h2c_done_irq register.

## Test plan
- Single handshake:
  - Stimulus: req[5]=1; DUT raises ack[5] 4 cycles after out[5]=1; drops ack 2 cycles after out[5]=0.
  - Response: out[5] high 1 cycle after req; status[5]=1 and one req_clr_we[5] pulse 1 cycle after ack low; no re-assert while req stays 1.
- Concurrent channels:
  - Stimulus: req=0x1 and req bit 127 set together, with acks at different times.
  - Response: both complete independently; h2c_done_irq=1 with done_enable[127]=1 only after bit 127 completes.
- Set/clear collision:
  - Stimulus: status_clear[5] pulsed in the same cycle status[5] sets.
  - Response: status[5] remains 1.
- Spurious ack:
  - Stimulus: ack[9]=1 with req[9]=0.
  - Response: spurious=1, h2c_intr_out[9] stays 0.
- Reset mid-handshake:
  - Stimulus: reset during ASSERT on bit 3.
  - Response: out[3]=0 immediately; after release with req[3]=1, out[3] re-asserts 1 cycle later.
- Pulse mode (CXS_H2C_INTR_PULSE_EN defined):
  - Stimulus: req[0]=1.
  - Response: out[0] high exactly 1 cycle; status[0]=1 on the edge that ends the pulse, with ack held at 0.
